// File: rtl/oled_spi_streamer.sv
// oled_spi_streamer: resets an SSD1306 panel, sends its init list, then streams framed pixel bytes over 4-wire SPI
module oled_spi_streamer #(
  parameter int CLK_DIV      = 4,
  parameter int RESET_CYCLES = 1000,
  parameter int FRAME_BYTES  = 1024
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data_to_send,
  output logic [9:0] byte_counter,
  output logic       sclk,
  output logic       sdin,
  output logic       cs_n,
  output logic       dc,
  output logic       res_n,
  output logic       init_done,
  output logic       frame_done
);
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam int RW = $clog2(RESET_CYCLES + 1);
  typedef enum logic [2:0] {RST_LOW, RST_WAIT, INIT, ADDR, FETCH, DATA} state_t;
  state_t st;
  logic [DW-1:0] dv;
  logic [2:0] bc;
  logic [3:0] idx;
  logic [RW-1:0] cnt;
  logic [7:0] sh, ld_byte;
  logic act, gap, dv_last, done, cnt_last, last, ld;
  // entries 0..7 are the init list, 8..13 the per-frame address window
  function automatic logic [7:0] cmd(input logic [3:0] i);
    case (i)
      4'd0:  return 8'hAE;
      4'd1:  return 8'h20;
      4'd2:  return 8'h00;
      4'd3:  return 8'h8D;
      4'd4:  return 8'h14;
      4'd5:  return 8'hA1;
      4'd6:  return 8'hC8;
      4'd7:  return 8'hAF;
      4'd8:  return 8'h21;
      4'd9:  return 8'h00;
      4'd10: return 8'h7F;
      4'd11: return 8'h22;
      4'd12: return 8'h00;
      default: return 8'h07;
    endcase
  endfunction
  // decide when a new byte starts and which byte it is
  always_comb begin
    dv_last  = dv == DW'(CLK_DIV - 1);
    done     = act & gap & dv_last;
    cnt_last = cnt == RW'(RESET_CYCLES - 1);
    last     = byte_counter == 10'(FRAME_BYTES - 1);
    ld       = (st == RST_WAIT & cnt_last) | ((st == INIT | st == ADDR) & done & idx != 4'd13)
             | (st == FETCH & cnt == RW'(1)) | (st == DATA & done & last);
    ld_byte  = st == FETCH ? data_to_send : cmd(st == RST_WAIT ? 4'd0 : st == DATA ? 4'd8 : idx + 4'd1);
  end
  // byte shifter plus sequencing FSM; a load overrides the shifter's end-of-byte idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      st <= RST_LOW;
      cnt <= '0;
      dv <= '0;
      bc <= '0;
      idx <= '0;
      sh <= '0;
      act <= 1'b0;
      gap <= 1'b0;
      sclk <= 1'b0;
      sdin <= 1'b0;
      cs_n <= 1'b1;
      dc <= 1'b0;
      res_n <= 1'b0;
      byte_counter <= '0;
      init_done <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      cnt <= cnt + 1'b1;
      if (act) begin
        dv <= dv_last ? '0 : dv + 1'b1;
        if (dv_last) begin
          if (gap) act <= 1'b0;
          else if (!sclk) sclk <= 1'b1;
          else begin
            sclk <= 1'b0;
            if (bc == 3'd7) begin
              gap <= 1'b1;
              cs_n <= 1'b1;
            end else begin
              bc <= bc + 3'd1;
              sdin <= sh[7];
              sh <= {sh[6:0], 1'b0};
            end
          end
        end
      end
      if (ld) begin
        act <= 1'b1;
        gap <= 1'b0;
        dv <= '0;
        bc <= '0;
        cs_n <= 1'b0;
        sclk <= 1'b0;
        dc <= st == FETCH;
        sdin <= ld_byte[7];
        sh <= {ld_byte[6:0], 1'b0};
      end
      case (st)
        RST_LOW: if (cnt_last) begin
          st <= RST_WAIT;
          res_n <= 1'b1;
          cnt <= '0;
        end
        RST_WAIT: if (cnt_last) begin
          st <= INIT;
          idx <= '0;
        end
        INIT: if (done) begin
          idx <= idx + 4'd1;
          if (idx == 4'd7) begin
            init_done <= 1'b1;
            st <= ADDR;
          end
        end
        ADDR: if (done) begin
          if (idx == 4'd13) begin
            st <= FETCH;
            byte_counter <= '0;
            cnt <= '0;
          end else idx <= idx + 4'd1;
        end
        FETCH: if (cnt == RW'(1)) st <= DATA;
        DATA: if (done) begin
          cnt <= '0;
          if (last) begin
            byte_counter <= '0;
            frame_done <= 1'b1;
            idx <= 4'd8;
            st <= ADDR;
          end else begin
            byte_counter <= byte_counter + 10'd1;
            st <= FETCH;
          end
        end
        default: st <= RST_LOW;
      endcase
    end
  end
endmodule
